// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode, operand forwarding and load-use stall.
// Define ID_EX_FORWARDING_EN for EX/MEM and MEM/WB forwarding; otherwise dependent instructions stall.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic [REGW-1:0]  id_rd,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             exmem_regwrite,
    input  logic [REGW-1:0]  exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_regwrite,
    input  logic [REGW-1:0]  memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic             stall,
    output logic             ex_valid,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] data_a,
    output logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [REGW-1:0]  ex_dest,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [WIDTH-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [REGW-1:0]  ex_rs, ex_rt;
    logic             ex_alusrc;
    logic [3:0]       dec_op;
    logic [WIDTH-1:0] fwd_a, fwd_b;
    logic             load_use, dep_stall;

    always_comb begin
        dec_op = OP_ADD;
        case (id_aluop)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_OR;
            default: begin
                case (id_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b100111: dec_op = OP_NOR;
                    default:   dec_op = OP_ADD;
                endcase
            end
        endcase
    end

    assign load_use = ex_valid & ex_memread & (ex_rt != '0)
                    & ((ex_rt == id_rs) | (ex_rt == id_rt)) & id_valid & ~flush;

`ifdef ID_EX_FORWARDING_EN
    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is hardwired zero.
    always_comb begin
        fwd_a = ex_rs_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs))
            fwd_a = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs))
            fwd_a = memwb_data;

        fwd_b = ex_rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rt))
            fwd_b = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rt))
            fwd_b = memwb_data;
    end

    assign dep_stall = 1'b0;
`else
    logic rs_dep, rt_dep;
    logic unused_fwd;

    assign fwd_a = ex_rs_data;
    assign fwd_b = ex_rt_data;

    // MEM/WB is covered by the write-first register file, so only EX and EX/MEM block.
    assign rs_dep = (id_rs != '0) & ((ex_valid & ex_regwrite & (ex_dest == id_rs))
                  | (exmem_regwrite & (exmem_rd == id_rs)));
    assign rt_dep = (id_rt != '0) & ((ex_valid & ex_regwrite & (ex_dest == id_rt))
                  | (exmem_regwrite & (exmem_rd == id_rt)));
    assign dep_stall = id_valid & ~flush & (rs_dep | rt_dep);

    assign unused_fwd = ^{exmem_result, memwb_regwrite, memwb_rd, memwb_data, ex_rs};
`endif

    assign stall         = load_use | dep_stall;
    assign data_a        = fwd_a;
    assign data_b        = ex_alusrc ? ex_imm : fwd_b;
    assign ex_store_data = fwd_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            operation   <= OP_ADD;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else if (!hold) begin
            if (flush || stall) begin
                ex_valid    <= 1'b0;
                operation   <= OP_ADD;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_memtoreg <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                operation   <= dec_op;
                ex_rs_data  <= id_rs_data;
                ex_rt_data  <= id_rt_data;
                ex_imm      <= id_imm;
                ex_rs       <= id_rs;
                ex_rt       <= id_rt;
                ex_dest     <= id_regdst ? id_rd : id_rt;
                ex_alusrc   <= id_alusrc;
                ex_regwrite <= id_regwrite & id_valid;
                ex_memread  <= id_memread & id_valid;
                ex_memwrite <= id_memwrite & id_valid;
                ex_memtoreg <= id_memtoreg & id_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic against a behavioural model.
// Expectations follow ID_EX_FORWARDING_EN when it is defined for the build.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic        stall, ex_valid;
    logic [3:0]  operation;
    logic [31:0] data_a, data_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

    id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .operation(operation),
        .data_a(data_a), .data_b(data_b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg)
    );

    always #5 clk = ~clk;

`ifdef ID_EX_FORWARDING_EN
    localparam logic fwd_on = 1'b1;
`else
    localparam logic fwd_on = 1'b0;
`endif

    // Expected content of the EX stage as an abstract instruction record.
    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, dest;
        logic        alusrc, rw, mr, mw, mt;
    } ex_t;

    ex_t m;
    int  n_cmp = 0;
    int  n_bad = 0;

    logic [5:0] fcode [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [3:0] fop   [6] = '{4'd2,  4'd6,  4'd0,  4'd1,  4'd7,  4'd12};

    function automatic logic [3:0] exp_op(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] r;
        r = 4'd2;
        if (aluop == 2'd1) r = 4'd6;
        if (aluop == 2'd3) r = 4'd1;
        if (aluop == 2'd2)
            for (int i = 0; i < 6; i++)
                if (fcode[i] == funct) r = fop[i];
        return r;
    endfunction

    function automatic logic [31:0] fwd_exp(input logic [4:0] idx, input logic [31:0] file_val);
        if (fwd_on && exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (fwd_on && memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_data;
        return file_val;
    endfunction

    function automatic logic busy(input logic [4:0] r);
        return r != 0 && ((m.v && m.rw && m.dest == r) || (exmem_regwrite && exmem_rd == r));
    endfunction

    function automatic logic exp_stall();
        logic lu;
        if (!id_valid || flush) return 1'b0;
        lu = m.v && m.mr && m.rt != 0 && (m.rt == id_rs || m.rt == id_rt);
        return lu || (!fwd_on && (busy(id_rs) || busy(id_rt)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '0;
        m.op = 4'd2;
    endtask

    task automatic model_update();
        if (hold) return;
        if (flush || exp_stall()) begin
            m.v = 1'b0; m.op = 4'd2;
            m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.mt = 1'b0;
        end else begin
            m.v = id_valid;
            m.op = exp_op(id_aluop, id_funct);
            m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt;
            m.dest = id_regdst ? id_rd : id_rt;
            m.alusrc = id_alusrc;
            m.rw = id_regwrite && id_valid;
            m.mr = id_memread && id_valid;
            m.mw = id_memwrite && id_valid;
            m.mt = id_memtoreg && id_valid;
        end
    endtask

    task automatic check_all();
        chk("stall", 32'(stall), 32'(exp_stall()));
        chk("ex_valid", 32'(ex_valid), 32'(m.v));
        chk("operation", 32'(operation), 32'(m.op));
        chk("ex_ctl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}),
            32'({m.rw, m.mr, m.mw, m.mt}));
        if (m.v) begin
            chk("data_a", data_a, fwd_exp(m.rs, m.rsd));
            chk("data_b", data_b, m.alusrc ? m.imm : fwd_exp(m.rt, m.rtd));
            chk("store_data", ex_store_data, fwd_exp(m.rt, m.rtd));
            chk("ex_dest", 32'(ex_dest), 32'(m.dest));
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc();
        #1 check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        hold = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_aluop = 0; id_funct = 0;
        id_alusrc = 0; id_regdst = 0; id_regwrite = 0;
        id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic id_instr(input logic [1:0] aluop, input logic [5:0] funct,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_aluop = aluop; id_funct = funct;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_regdst = 1; id_regwrite = 1; id_alusrc = 0;
        id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    task automatic id_load(input logic [4:0] rs, input logic [4:0] rt);
        id_instr(2'b00, 6'h0, rs, rt, 5'd0, 32'h100, 32'h0);
        id_regdst = 0; id_alusrc = 1; id_imm = 32'h8;
        id_memread = 1; id_memtoreg = 1;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_operation", 32'(operation), 32'd2);
        chk("rst_data_a", data_a, 32'd0);
        chk("rst_data_b", data_b, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 0;

        // R-type add
        id_instr(2'b10, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        cyc();
        idle();
        #1;
        chk("radd_op", 32'(operation), 32'd2);
        chk("radd_a", data_a, 32'd5);
        chk("radd_b", data_b, 32'd7);
        chk("radd_valid", 32'(ex_valid), 32'd1);
        cyc();

        // forwarding priority and r0
        id_instr(2'b00, 6'h0, 5'd3, 5'd2, 5'd6, 32'h99, 32'h1);
        cyc();
        idle();
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_data = 32'h22;
        #1 chk("fwd_exmem", data_a, fwd_on ? 32'h11 : 32'h99);
        exmem_regwrite = 0;
        #1 chk("fwd_memwb", data_a, fwd_on ? 32'h22 : 32'h99);
        cyc();
        id_instr(2'b00, 6'h0, 5'd0, 5'd2, 5'd6, 32'h55, 32'h1);
        exmem_regwrite = 1; exmem_rd = 0; memwb_regwrite = 1; memwb_rd = 0;
        cyc();
        id_valid = 0;
        #1 chk("fwd_r0", data_a, 32'h55);
        cyc();
        idle();
        cyc();

        // load-use, with a hold while the stall is pending
        id_load(5'd1, 5'd4);
        cyc();
        id_instr(2'b10, 6'h20, 5'd4, 5'd5, 5'd8, 32'h3, 32'h4);
        hold = 1;
        #1 chk("lu_stall_hold", 32'(stall), 32'd1);
        cyc();
        cyc();
        hold = 0;
        #1 chk("lu_stall", 32'(stall), 32'd1);
        cyc();
        #1;
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_rw", 32'(ex_regwrite), 32'd0);
        chk("lu_after_stall", 32'(stall), 32'd0);
        cyc();
        idle();
        #1 chk("lu_add_valid", 32'(ex_valid), 32'd1);
        cyc();

        // flush overrides stall
        id_load(5'd1, 5'd4);
        cyc();
        id_instr(2'b10, 6'h20, 5'd4, 5'd5, 5'd8, 32'h3, 32'h4);
        flush = 1;
        #1 chk("flush_stall", 32'(stall), 32'd0);
        cyc();
        idle();
        #1 chk("flush_bubble", 32'(ex_valid), 32'd0);
        cyc();

        // hold freezes EX; reset mid-hold clears asynchronously
        id_instr(2'b01, 6'h0, 5'd6, 5'd7, 5'd9, 32'h1234, 32'h40);
        cyc();
        for (int i = 0; i < 3; i++) begin
            id_instr(2'b11, 6'h0, 5'd1, 5'd2, 5'd10, $urandom, $urandom);
            hold = 1;
            #1;
            chk("hold_op", 32'(operation), 32'd6);
            chk("hold_a", data_a, 32'h1234);
            chk("hold_dest", 32'(ex_dest), 32'd9);
            cyc();
        end
        #1 reset = 1;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_op", 32'(operation), 32'd2);
        chk("async_rst_a", data_a, 32'd0);
        chk("async_rst_rw", 32'(ex_regwrite), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        idle();

        // unknown funct and or-immediate
        id_instr(2'b10, 6'h00, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8);
        cyc();
        id_instr(2'b11, 6'h25, 5'd1, 5'd2, 5'd3, 32'h9, 32'h8);
        id_alusrc = 1; id_imm = 32'hFFFF_FFFC;
        #1 chk("funct0_op", 32'(operation), 32'd2);
        cyc();
        idle();
        #1;
        chk("ori_op", 32'(operation), 32'd1);
        chk("ori_imm", data_b, 32'hFFFF_FFFC);
        cyc();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_aluop = 2'($urandom_range(0, 3));
            id_funct = ($urandom_range(0, 1) == 1) ? fcode[$urandom_range(0, 5)]
                                                   : 6'($urandom_range(0, 63));
            id_alusrc = 1'($urandom_range(0, 1));
            id_regdst = 1'($urandom_range(0, 1));
            id_regwrite = 1'($urandom_range(0, 1));
            id_memread = ($urandom_range(0, 2) == 0);
            id_memwrite = ($urandom_range(0, 3) == 0);
            id_memtoreg = 1'($urandom_range(0, 1));
            exmem_regwrite = 1'($urandom_range(0, 1));
            exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_regwrite = 1'($urandom_range(0, 1));
            memwb_rd = 5'($urandom_range(0, 7));
            memwb_data = $urandom;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that directly feeds the 4-bit-opcode execute ALU (operation, data_a, data_b).
- Captures decoded instruction fields and control each cycle.
- Decodes aluop/funct into the ALU operation code.
- Forwards results from EX/MEM and MEM/WB, detects load-use hazards, and inserts bubbles on stall or flush.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- hold  in  1  global freeze (memory wait); ID/EX register keeps its contents
- flush  in  1  branch/jump redirect; load a bubble
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  REGW  register indices
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate
- id_funct  in  6  instruction funct field
- id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits
- exmem_regwrite  in  1, exmem_rd  in  REGW, exmem_result  in  WIDTH  EX/MEM forward source
- memwb_regwrite  in  1, memwb_rd  in  REGW, memwb_data  in  WIDTH  MEM/WB forward source
- stall  out  1  load-use hazard; upstream holds PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- operation  out  4  ALU opcode
- data_a, data_b  out  WIDTH  ALU operands
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_dest  out  REGW  id_rd if regdst, else id_rt (registered)
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control, forced 0 when ex_valid=0

Behaviour:
- Reset (asynchronous, immediate): all registers 0 except operation = 4'b0010 (add).
  - ex_valid=0, data_a=data_b=0, stall=0.
- Latency: one clock from ID inputs to registered EX fields.
  - Forwarding muxes are combinational on the registered rs/rt data.
- Update priority each rising edge:
  - hold: retain all.
  - else flush: bubble.
  - else stall: bubble.
  - else capture ID inputs with ex_valid=id_valid.
- Bubble: ex_valid=0, all write/mem controls 0, operation=0010.
- ALU decode, performed at capture:
  - aluop 00 → 0010; aluop 01 → 0110; aluop 11 → 0001.
  - aluop 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100; any other funct → 0010.
- stall = ex_valid & ex_memread & (ex_rt≠0) & (ex_rt==id_rs | ex_rt==id_rt) & id_valid & ~flush.
  - Combinational; asserted for exactly one cycle per load-use pair unless hold is active.
- Forwarding per source (rs for data_a; rt for data_b/ex_store_data):
  - exmem_regwrite & exmem_rd≠0 & match → exmem_result;
  - else memwb_regwrite & memwb_rd≠0 & match → memwb_data;
  - else registered file value.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- data_b = ex_alusrc ? ex_imm : forwarded rt.
- Simultaneous flush and stall: bubble, stall=0.
- hold during stall: stall stays asserted while hold=1; the register is not bubbled until hold drops.

Optional Feature:
- Macro ID_EX_FORWARDING_EN.
- Defined: forwarding as above.
- Undefined:
  - Operands come straight from the registered file data (data_b still selects imm on alusrc).
  - stall additionally asserts when id_valid and a nonzero id_rs/id_rt matches ex_dest (ex_valid & ex_regwrite) or exmem_rd (exmem_regwrite).
  - The register file is write-first, so MEM/WB needs no stall.

Test Plan:
- R-type add: aluop=10, funct=100000, rs_data=5, rt_data=7, no forward matches → next cycle operation=0010, data_a=5, data_b=7, ex_valid=1.
- Double forward: ex rs=3; exmem_rd=3 (regwrite=1, result=0x11) and memwb_rd=3 (data=0x22) → data_a=0x11. Repeat with exmem_regwrite=0 → 0x22. Repeat with rs=0 → file value.
- Load-use: EX holds lw with rt=4; ID add uses rs=4 → stall=1 for one cycle, next cycle ex_valid=0 and ex_regwrite=0, then the add captured with stall=0.
- Flush with stall together: flush=1 and load-use condition true → stall=0, bubble loaded.
- hold=1 for 3 cycles with new ID inputs → all EX outputs unchanged. Assert reset mid-hold → outputs reset immediately, before the next clock edge.
- aluop=10, funct=000000 → operation=0010; aluop=11 → operation=0001, alusrc=1 → data_b=id_imm (0xFFFF_FFFC).
